// File: rtl/pid_pkg.sv
// Shared FSM type and width helpers for the pid_core PID controller.
package pid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    PTERM,
    ITERM,
    DTERM,
    DONE
  } pid_state_t;

  localparam int ERR_EXTRA_W  = 1;
  localparam int DIFF_EXTRA_W = 2;
  localparam int ACC_EXTRA_W  = 2;

  function automatic int err_width(input int data_w);
    return data_w + ERR_EXTRA_W;
  endfunction

  function automatic int diff_width(input int data_w);
    return data_w + DIFF_EXTRA_W;
  endfunction

  function automatic int acc_width(input int acc_w, input int gain_w);
    return acc_w + gain_w + ACC_EXTRA_W;
  endfunction

endpackage

// File: rtl/pid_sat.sv
// Signed clamp from IN_W to OUT_W bits with overflow direction flags.
// SYMMETRIC=1 clamps to +/-(2^(OUT_W-1)-1); otherwise the full two's complement range.
module pid_sat #(
  parameter int IN_W      = 17,
  parameter int OUT_W     = 16,
  parameter bit SYMMETRIC = 1'b0
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    hi,
  output logic                    lo
);

  localparam logic signed [IN_W-1:0] MAX_V =
    {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = SYMMETRIC ? -MAX_V :
    {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    hi   = (din > MAX_V);
    lo   = (din < MIN_V);
    dout = din[OUT_W-1:0];
    if (hi) begin
      dout = MAX_V[OUT_W-1:0];
    end else if (lo) begin
      dout = MIN_V[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/pid_core.sv
// Fixed-point PID core stepping P, I and optional D terms through one shared multiplier.
// Define PID_DERIV_EN to include the DTERM stage, the e_prev register and the kd gain.
module pid_core
  import pid_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GAIN_W = 8,
  parameter int FRAC_W = 4,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] setpoint,
  input  logic [DATA_W-1:0] measurement,
  input  logic [GAIN_W-1:0] kp,
  input  logic [GAIN_W-1:0] ki,
  input  logic [GAIN_W-1:0] kd,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] ctrl_out,
  output logic              overrun
);

  localparam int E_W  = err_width(DATA_W);
  localparam int D_W  = diff_width(DATA_W);
  localparam int A_W  = acc_width(ACC_W, GAIN_W);
  localparam int OP_W = (ACC_W > D_W) ? ACC_W : D_W;
  localparam int P_W  = GAIN_W + 1 + OP_W;

  pid_state_t               state_q, state_d;
  logic [DATA_W-1:0]        sp_q, sp_d, meas_q, meas_d;
  logic [GAIN_W-1:0]        kp_q, kp_d, ki_q, ki_d;
  logic signed [E_W-1:0]    e_q, e_d;
  logic signed [ACC_W-1:0]  integ_q, integ_d;
  logic signed [A_W-1:0]    acc_q, acc_d;
  logic                     sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;
  logic                     overrun_q, overrun_d;
  logic [DATA_W-1:0]        ctrl_q, ctrl_d;

  logic                     accept, load_out;
  logic [GAIN_W-1:0]        mul_gain;
  logic signed [OP_W-1:0]   mul_op;
  logic signed [P_W-1:0]    prod;
  logic signed [A_W-1:0]    prod_ext, acc_sum, shifted;
  logic signed [ACC_W:0]    integ_sum;
  logic signed [ACC_W-1:0]  integ_clamped, integ_new;
  logic                     integ_hi_unused, integ_lo_unused;
  logic                     e_pos, e_neg, integ_hold;
  logic signed [DATA_W-1:0] out_clamped;
  logic                     out_hi, out_lo;

`ifdef PID_DERIV_EN
  logic [GAIN_W-1:0]        kd_q, kd_d;
  logic signed [E_W-1:0]    e_prev_q, e_prev_d;
  logic signed [D_W-1:0]    diff;

  assign diff = D_W'(e_q) - D_W'(e_prev_q);
`else
  logic kd_unused;

  assign kd_unused = ^kd;
`endif

  assign accept = sample_valid && ((state_q == IDLE) || (state_q == DONE));

  // Integrator holds while the last output was saturated in the direction e pushes.
  assign e_neg      = e_q[E_W-1];
  assign e_pos      = !e_q[E_W-1] && (e_q != '0);
  assign integ_hold = (sat_hi_q && e_pos) || (sat_lo_q && e_neg);
  assign integ_sum  = (ACC_W+1)'(integ_q) + (ACC_W+1)'(e_q);
  assign integ_new  = integ_hold ? integ_q : integ_clamped;

  pid_sat #(.IN_W(ACC_W+1), .OUT_W(ACC_W), .SYMMETRIC(1'b1)) u_integ_sat (
    .din  (integ_sum),
    .dout (integ_clamped),
    .hi   (integ_hi_unused),
    .lo   (integ_lo_unused)
  );

  always_comb begin
    mul_gain = '0;
    mul_op   = '0;
    case (state_q)
      PTERM: begin
        mul_gain = kp_q;
        mul_op   = OP_W'(e_q);
      end
      ITERM: begin
        mul_gain = ki_q;
        mul_op   = OP_W'(integ_new);
      end
`ifdef PID_DERIV_EN
      DTERM: begin
        mul_gain = kd_q;
        mul_op   = OP_W'(diff);
      end
`endif
      default: ;
    endcase
  end

  assign prod     = $signed({1'b0, mul_gain}) * mul_op;
  assign prod_ext = A_W'(prod);
  assign acc_sum  = acc_q + prod_ext;
  assign shifted  = acc_sum >>> FRAC_W;

  pid_sat #(.IN_W(A_W), .OUT_W(DATA_W), .SYMMETRIC(1'b0)) u_out_sat (
    .din  (shifted),
    .dout (out_clamped),
    .hi   (out_hi),
    .lo   (out_lo)
  );

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    meas_d    = meas_q;
    kp_d      = kp_q;
    ki_d      = ki_q;
    e_d       = e_q;
    integ_d   = integ_q;
    acc_d     = acc_q;
    sat_hi_d  = sat_hi_q;
    sat_lo_d  = sat_lo_q;
    overrun_d = overrun_q;
    ctrl_d    = ctrl_q;
    load_out  = 1'b0;
`ifdef PID_DERIV_EN
    kd_d      = kd_q;
    e_prev_d  = e_prev_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) state_d = ERR;
      end
      ERR: begin
        e_d     = $signed({sp_q[DATA_W-1], sp_q}) - $signed({meas_q[DATA_W-1], meas_q});
        state_d = PTERM;
      end
      PTERM: begin
        acc_d   = prod_ext;
        state_d = ITERM;
      end
      ITERM: begin
        integ_d = integ_new;
        acc_d   = acc_sum;
`ifdef PID_DERIV_EN
        state_d = DTERM;
`else
        state_d  = DONE;
        load_out = 1'b1;
`endif
      end
`ifdef PID_DERIV_EN
      DTERM: begin
        acc_d    = acc_sum;
        e_prev_d = e_q;
        state_d  = DONE;
        load_out = 1'b1;
      end
`endif
      DONE: begin
        state_d = accept ? ERR : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      sp_d   = setpoint;
      meas_d = measurement;
      kp_d   = kp;
      ki_d   = ki;
`ifdef PID_DERIV_EN
      kd_d   = kd;
`endif
    end else if (sample_valid) begin
      overrun_d = 1'b1;
    end

    // The output and saturation flags are taken from the final accumulator sum.
    if (load_out) begin
      ctrl_d   = out_clamped;
      sat_hi_d = out_hi;
      sat_lo_d = out_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sp_q      <= '0;
      meas_q    <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      e_q       <= '0;
      integ_q   <= '0;
      acc_q     <= '0;
      sat_hi_q  <= 1'b0;
      sat_lo_q  <= 1'b0;
      overrun_q <= 1'b0;
      ctrl_q    <= '0;
`ifdef PID_DERIV_EN
      kd_q      <= '0;
      e_prev_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      meas_q    <= meas_d;
      kp_q      <= kp_d;
      ki_q      <= ki_d;
      e_q       <= e_d;
      integ_q   <= integ_d;
      acc_q     <= acc_d;
      sat_hi_q  <= sat_hi_d;
      sat_lo_q  <= sat_lo_d;
      overrun_q <= overrun_d;
      ctrl_q    <= ctrl_d;
`ifdef PID_DERIV_EN
      kd_q      <= kd_d;
      e_prev_q  <= e_prev_d;
`endif
    end
  end

  assign busy      = (state_q == ERR) || (state_q == PTERM) ||
                     (state_q == ITERM) || (state_q == DTERM);
  assign out_valid = (state_q == DONE);
  assign ctrl_out  = ctrl_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pid_core.sv
// Bench for pid_core: directed literal cases plus randomized traffic against a sample-level model.
// Honors PID_DERIV_EN the same way as the design.
module tb_pid_core;

  localparam int DATA_W = 8;
  localparam int GAIN_W = 8;
  localparam int FRAC_W = 4;
  localparam int ACC_W  = 16;
`ifdef PID_DERIV_EN
  localparam int LAT   = 5;
  localparam bit DERIV = 1'b1;
`else
  localparam int LAT   = 4;
  localparam bit DERIV = 1'b0;
`endif
  localparam longint INTEG_MAX = (longint'(1) <<< (ACC_W-1)) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] setpoint = '0;
  logic [DATA_W-1:0] measurement = '0;
  logic [GAIN_W-1:0] kp = '0;
  logic [GAIN_W-1:0] ki = '0;
  logic [GAIN_W-1:0] kd = '0;
  logic              busy, out_valid, overrun;
  logic [DATA_W-1:0] ctrl_out;

  int errors = 0;
  int checks = 0;

  pid_core #(.DATA_W(DATA_W), .GAIN_W(GAIN_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .setpoint     (setpoint),
    .measurement  (measurement),
    .kp           (kp),
    .ki           (ki),
    .kd           (kd),
    .busy         (busy),
    .out_valid    (out_valid),
    .ctrl_out     (ctrl_out),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic longint clampv(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Sample-level reference: each accepted sample's result is computed whole at acceptance
  // and becomes visible LAT cycles later.
  bit     m_ready = 1'b0;
  longint cyc = 0;
  longint acc_cyc = 0;
  bit     inflight = 1'b0;
  longint m_integ = 0, m_eprev = 0, m_ctrl = 0;
  bit     m_hi = 1'b0, m_lo = 1'b0, m_overrun = 1'b0;
  longint p_integ = 0, p_eprev = 0, p_ctrl = 0;
  bit     p_hi = 1'b0, p_lo = 1'b0;
  bit     exp_valid = 1'b0, exp_busy = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_ready   = 1'b1;
        inflight  = 1'b0;
        m_integ   = 0;
        m_eprev   = 0;
        m_ctrl    = 0;
        m_hi      = 1'b0;
        m_lo      = 1'b0;
        m_overrun = 1'b0;
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
      end else begin
        bit accepted;
        accepted  = 1'b0;
        exp_valid = 1'b0;
        if (sample_valid) begin
          if (!inflight) accepted = 1'b1;
          else m_overrun = 1'b1;
        end
        if (inflight && (cyc - acc_cyc == LAT - 1)) begin
          m_integ   = p_integ;
          m_eprev   = p_eprev;
          m_ctrl    = p_ctrl;
          m_hi      = p_hi;
          m_lo      = p_lo;
          exp_valid = 1'b1;
          inflight  = 1'b0;
        end
        if (accepted) begin
          longint e, ni, acc, y;
          e  = longint'($signed(setpoint)) - longint'($signed(measurement));
          ni = m_integ;
          if (!((m_hi && e > 0) || (m_lo && e < 0)))
            ni = clampv(m_integ + e, -INTEG_MAX, INTEG_MAX);
          acc = longint'(kp) * e + longint'(ki) * ni;
          if (DERIV) acc = acc + longint'(kd) * (e - m_eprev);
          y       = acc >>> FRAC_W;
          p_ctrl  = clampv(y, -128, 127);
          p_hi    = (y > 127);
          p_lo    = (y < -128);
          p_integ = ni;
          p_eprev = DERIV ? e : m_eprev;
          inflight = 1'b1;
          acc_cyc  = cyc;
        end
        exp_busy = inflight;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_ready) begin
        checkOutput("busy", longint'(busy), longint'(exp_busy));
        checkOutput("out_valid", longint'(out_valid), longint'(exp_valid));
        checkOutput("ctrl_out", longint'($signed(ctrl_out)), m_ctrl);
        checkOutput("overrun", longint'(overrun), longint'(m_overrun));
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input int sp, input int meas, input int kpv, input int kiv,
                               input int kdv, input int exp_ctrl, input string name);
    int k;
    @(negedge clk);
    sample_valid = 1'b1;
    setpoint     = 8'(sp);
    measurement  = 8'(meas);
    kp           = 8'(kpv);
    ki           = 8'(kiv);
    kd           = 8'(kdv);
    @(negedge clk);
    sample_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput({name, "_latency"}, longint'(k), longint'(LAT));
    checkOutput({name, "_ctrl"}, longint'($signed(ctrl_out)), longint'(exp_ctrl));
  endtask

  task automatic countPulses(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
  endtask

  initial begin
    int pulses, k;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_busy", longint'(busy), 0);
    checkOutput("reset_out_valid", longint'(out_valid), 0);
    checkOutput("reset_ctrl", longint'($signed(ctrl_out)), 0);
    checkOutput("reset_overrun", longint'(overrun), 0);

    applyStimulus(50, 20, 16, 0, 0, 30, "p_basic");

    doReset();
    applyStimulus(100, 0, 255, 0, 0, 127, "p_sat_hi");
    applyStimulus(-100, 0, 255, 0, 0, -128, "p_sat_lo");

    doReset();
    applyStimulus(10, 0, 0, 16, 0, 10, "i_step1");
    applyStimulus(10, 0, 0, 16, 0, 20, "i_step2");
    applyStimulus(10, 0, 0, 16, 0, 30, "i_step3");

    doReset();
    applyStimulus(10, 0, 0, 255, 0, 127, "aw_sat");
    applyStimulus(5, 0, 0, 255, 0, 127, "aw_hold");
    applyStimulus(-5, 0, 0, 255, 0, 79, "aw_release");

`ifdef PID_DERIV_EN
    doReset();
    applyStimulus(0, 0, 0, 0, 16, 0, "d_step0");
    applyStimulus(10, 0, 0, 0, 16, 10, "d_step1");
    applyStimulus(10, 0, 0, 0, 16, 0, "d_step2");
`endif

    // Sample offered during PTERM is dropped and leaves the sticky flag set.
    doReset();
    @(negedge clk);
    sample_valid = 1'b1; setpoint = 8'd50; measurement = 8'd20;
    kp = 8'd16; ki = 8'd0; kd = 8'd0;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    sample_valid = 1'b1; setpoint = 8'd100;
    @(negedge clk);
    sample_valid = 1'b0;
    checkOutput("ovr_set", longint'(overrun), 1);
    k = 3;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("ovr_latency", longint'(k), longint'(LAT));
    checkOutput("ovr_ctrl", longint'($signed(ctrl_out)), 30);
    applyStimulus(10, 0, 16, 0, 0, 10, "ovr_next");
    checkOutput("ovr_sticky", longint'(overrun), 1);

    doReset();
    @(negedge clk);
    sample_valid = 1'b1;
    for (int i = 1; i <= 4 * LAT; i++) begin
      setpoint = 8'($urandom); measurement = 8'($urandom);
      kp = 8'($urandom); ki = 8'($urandom_range(0, 31)); kd = 8'($urandom);
      @(negedge clk);
      if (out_valid) pulses++;
    end
    sample_valid = 1'b0;
    checkOutput("stream_pulses", longint'(pulses), 4);
    pulses = 0;

    // Reset during ITERM abandons the computation.
    doReset();
    @(negedge clk);
    sample_valid = 1'b1; setpoint = 8'd30; measurement = 8'd0;
    kp = 8'd16; ki = 8'd0; kd = 8'd0;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", longint'(busy), 0);
    checkOutput("midrst_out_valid", longint'(out_valid), 0);
    checkOutput("midrst_ctrl", longint'($signed(ctrl_out)), 0);
    checkOutput("midrst_overrun", longint'(overrun), 0);
    countPulses(8, pulses);
    checkOutput("midrst_no_pulse", longint'(pulses), 0);
    applyStimulus(7, 0, 16, 0, 0, 7, "after_rst");

    @(negedge clk);
    rst = 1'b1; sample_valid = 1'b1; setpoint = 8'd40; kp = 8'd16;
    @(negedge clk);
    rst = 1'b0; sample_valid = 1'b0;
    countPulses(8, pulses);
    checkOutput("rst_sample_discard", longint'(pulses), 0);

    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 63) == 0);
      sample_valid = ($urandom_range(0, 2) == 0);
      setpoint     = 8'($urandom);
      measurement  = 8'($urandom);
      kp           = 8'($urandom);
      ki           = 8'($urandom_range(0, 40));
      kd           = 8'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    sample_valid = 1'b0;
    for (int i = 0; i < 2 * LAT; i++) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
